// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer logic.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 3;

  // Pointer arithmetic runs on a 32-bit word; callers zero-extend and truncate.
  // Zero upper bits leave the Gray/binary mapping of the low bits unchanged,
  // so one function pair serves any pointer width up to 32.
  localparam int PTR_WORD_W = 32;
  typedef logic [PTR_WORD_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin = '0;
    bin[PTR_WORD_W-1] = gray[PTR_WORD_W-1];
    for (int i = PTR_WORD_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray_cnt.sv
// Enable-driven binary pointer with a registered Gray copy for CDC.
// The Gray output is taken straight from a flop, so exactly one bit changes per increment.
module fifo_gray_cnt
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_ADDR_WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] bin_next,
  output logic [WIDTH-1:0] gray
);

  // Next pointer value; wraps naturally modulo 2**WIDTH.
  always_comb begin
    bin_next = bin + WIDTH'(en);
  end

  // Binary and Gray pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next;
      gray <= WIDTH'(bin2gray(PTR_WORD_W'(bin_next)));
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the async FIFO: write address, Gray write pointer,
// and full / almost_full / level / sticky overflow, all derived from the
// read pointer already synchronized into this clock domain.
// The synchronized read pointer lags the real one, so full may stay set a few
// cycles after a read but never clears early.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_sync,
  input  logic                  ovf_clr,
  output logic                  wclken,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] level_next;

  // A write is accepted only when the FIFO is not full.
  always_comb begin
    wclken = winc & ~full;
  end

  fifo_gray_cnt #(
    .WIDTH (PW)
  ) u_wptr (
    .clk      (clk),
    .rst      (rst),
    .en       (wclken),
    .bin      (wbin),
    .bin_next (wbin_next),
    .gray     (wptr_gray)
  );

  // wbin is already a register, so the address needs no extra flop.
  assign waddr = wbin[ADDR_WIDTH-1:0];

  // Look-ahead flag inputs: full and level are evaluated on the post-write pointer.
  // Full means the write pointer is one lap ahead, which in Gray form is the read
  // pointer with its two MSBs inverted.
  always_comb begin
    rbin       = PW'(gray2bin(PTR_WORD_W'(rptr_sync)));
    wgray_next = PW'(bin2gray(PTR_WORD_W'(wbin_next)));
    full_cmp   = {~rptr_sync[ADDR_WIDTH:ADDR_WIDTH-1], rptr_sync[ADDR_WIDTH-2:0]};
    level_next = wbin_next - rbin;
  end

  // Registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
    end else begin
      full        <= (wgray_next == full_cmp);
      almost_full <= (level_next >= PW'(AFULL_THRESH));
      wr_level    <= level_next;
    end
  end

  // Sticky overflow; a blocked write wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (winc && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-domain controller for the async FIFO. It generates the binary write address and the registered Gray-coded write pointer that crosses to the read domain through the DF_SYNC chain. It consumes the read pointer that has already been synchronized into the write clock domain, and from it derives full, almost_full, fill level and a sticky overflow flag. It pairs with the read-side synchronizer, one instance per FIFO.

Parameters:
ADDR_WIDTH, 3, FIFO address bits; depth = 2**ADDR_WIDTH; pointer width = ADDR_WIDTH+1 (matches synchronizer ptr_width=4).
AFULL_THRESH, 6, fill level at or above which almost_full asserts; legal range 1..2**ADDR_WIDTH.

Ports:
clk  input  1  write-domain clock
rst  input  1  asynchronous reset, active-low
winc  input  1  write request, sampled each clk
rptr_sync  input  ADDR_WIDTH+1  Gray read pointer, already synchronized into clk domain
ovf_clr  input  1  clears sticky overflow
wclken  output  1  memory write enable = winc & ~full (combinational)
waddr  output  ADDR_WIDTH  memory write address, = wbin[ADDR_WIDTH-1:0] (registered)
wptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, to synchronizer unsync_data
full  output  1  registered full flag
almost_full  output  1  registered, level >= AFULL_THRESH
wr_level  output  ADDR_WIDTH+1  registered fill level as seen from write domain, 0..2**ADDR_WIDTH
overflow  output  1  sticky: a write was attempted while full

Behaviour:
- Reset (rst=0, async): wbin=0, wptr_gray=0, waddr=0, full=0, almost_full=0, wr_level=0, overflow=0.
- Internal: wbin (ADDR_WIDTH+1 bits, binary). wbin_next = wbin + (winc & ~full), modulo 2**(ADDR_WIDTH+1); natural wrap, no saturation.
- Each posedge: wbin<=wbin_next; wptr_gray<=wbin_next ^ (wbin_next>>1); waddr<=wbin_next[ADDR_WIDTH-1:0].
- Only one wptr_gray bit changes per cycle; no combinational path to wptr_gray (feeds CDC).
- rbin = Gray-to-binary of rptr_sync (XOR prefix from MSB), combinational.
- full <= (gray(wbin_next) == {~rptr_sync[ADDR_WIDTH:ADDR_WIDTH-1], rptr_sync[ADDR_WIDTH-2:0]}).
- wr_level <= wbin_next - rbin, modulo 2**(ADDR_WIDTH+1).
- almost_full <= (wbin_next - rbin) >= AFULL_THRESH.
- Latency: a write updates full, level and almost_full at the same clk edge that advances the pointer. A read becomes visible only after synchronizer latency plus 1 cycle. Full is therefore pessimistic (deasserts late), never optimistic.
- Write while full: wclken=0, pointer unchanged, overflow<=1 at that edge.
- overflow: set has priority over ovf_clr in the same cycle; otherwise ovf_clr=1 clears it.
- rptr_sync advancing while winc=1 in the same cycle: both are applied; full and level are computed from the new wbin_next and the current rptr_sync.
- Reset mid-operation: immediate clear of all state. Both domains must be reset together; no partial-reset recovery is supported.
- rptr_sync is treated as arbitrary Gray input. The block does not check that it stays monotonic.

Decomposition:
- Shared package fifo_pkg:
  - functions bin2gray and gray2bin, parameterised by width;
  - constant FIFO_ADDR_WIDTH default 3.
- Sub-module fifo_gray_cnt (enable-driven binary counter with registered Gray output and next-value output). It will be reused by the read-side controller.
- Full, level, almost_full and overflow logic stay in fifo_wr_ctrl.

Test Plan (ADDR_WIDTH=3, AFULL_THRESH=6):
1. Reset: assert rst=0 mid-stream -> all outputs 0 immediately (asynchronously, without waiting for a clk edge); after release, the first winc gives wptr_gray=0001, waddr=1.
2. Fill from empty, rptr_sync=0000, winc=1 for 8 cycles -> wptr_gray sequence 0001,0011,0010,0110,0111,0101,0100,1100. almost_full=1 after the 6th write; full=1 and wr_level=8 after the 8th.
3. Overflow: hold winc=1 with full=1 -> wclken=0, wptr_gray stays 1100, overflow=1. Pulse ovf_clr for one cycle with winc=0 -> overflow=0. Repeat with ovf_clr and a blocked write in the same cycle -> overflow stays 1.
4. Drain visibility: from full, drive rptr_sync=0110 (bin 4) -> next edge full=0, wr_level=4, almost_full=0.
5. Wrap-around: with a reader model keeping the FIFO non-full, perform 16 total writes -> wbin wraps to 0, wptr_gray=0000, waddr=0. Every wptr_gray transition has Hamming distance 1.
6. Simultaneous events: winc=1 and rptr_sync advances by 1 in the same cycle at level 7 -> level stays 7, full=0, wclken=1.
